// File: rtl/wasm_run_monitor_pkg.sv
// wasm_run_monitor_pkg: FSM state encoding and error codes shared by the run monitor files.
package wasm_run_monitor_pkg;

   typedef enum logic [1:0] {
      RUNMON_IDLE = 2'd0,
      RUNMON_HOLD = 2'd1,
      RUNMON_RUN  = 2'd2,
      RUNMON_DONE = 2'd3
   } runmon_state_e;

   typedef logic [2:0] runmon_err_t;

   localparam runmon_err_t RUNMON_ERR_NONE         = 3'd0;
   localparam runmon_err_t RUNMON_ERR_INSTR        = 3'd1;
   localparam runmon_err_t RUNMON_ERR_STACK_EXCEED = 3'd2;
   localparam runmon_err_t RUNMON_ERR_EMPTY_POP    = 3'd3;
   localparam runmon_err_t RUNMON_ERR_TIMEOUT      = 3'd4;

endpackage

// File: rtl/wasm_fault_encoder.sv
// wasm_fault_encoder: priority-encodes the core fault bits (instr_error first) into an error code.
module wasm_fault_encoder
   import wasm_run_monitor_pkg::*;
(
   input  logic        i_instr_error,
   input  logic        i_stack_exceed,
   input  logic        i_stack_empty_pop,
   output runmon_err_t o_code,
   output logic        o_any
);
   assign o_any  = i_instr_error | i_stack_exceed | i_stack_empty_pop;
   assign o_code = i_instr_error     ? RUNMON_ERR_INSTR :
                   i_stack_exceed    ? RUNMON_ERR_STACK_EXCEED :
                   i_stack_empty_pop ? RUNMON_ERR_EMPTY_POP : RUNMON_ERR_NONE;
endmodule

// File: rtl/wasm_run_monitor.sv
// wasm_run_monitor: resets the core, times the run, enforces a watchdog budget; WASM_RUN_STATS_EN adds min/max pass cycles.
module wasm_run_monitor
   import wasm_run_monitor_pkg::*;
#(
   parameter int CNT_W          = 32,
   parameter int RUN_CNT_W      = 8,
   parameter int RST_HOLD       = 2,
   parameter int TIMEOUT_CYCLES = 500
) (
   input  logic                 i_clk,
   input  logic                 i_rst_n,
   input  logic                 i_start,
   input  logic                 i_clear,
   input  logic                 i_instr_finish,
   input  logic                 i_instr_error,
   input  logic                 i_stack_exceed,
   input  logic                 i_stack_empty_pop,
   output logic                 o_core_rst_n,
   output logic                 o_busy,
   output logic                 o_done,
   output logic                 o_pass,
   output logic [2:0]           o_err_code,
   output logic [CNT_W-1:0]     o_cycle_cnt,
   output logic [CNT_W-1:0]     o_err_cycle,
`ifdef WASM_RUN_STATS_EN
   output logic [CNT_W-1:0]     o_min_cycles,
   output logic [CNT_W-1:0]     o_max_cycles,
`endif
   output logic [RUN_CNT_W-1:0] o_run_cnt
);
   localparam int                HOLD_W    = $clog2(RST_HOLD + 1);
   localparam logic [HOLD_W-1:0] HOLD_INIT = HOLD_W'(RST_HOLD - 1);
   localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(TIMEOUT_CYCLES - 1);

   runmon_state_e          state_q, state_d;
   logic [HOLD_W-1:0]      hold_q, hold_d;
   logic                   core_rst_n_q, core_rst_n_d;
   logic                   pass_q, pass_d;
   runmon_err_t            err_q, err_d;
   logic [CNT_W-1:0]       cnt_q, cnt_d;
   logic [CNT_W-1:0]       err_cycle_q, err_cycle_d;
   logic [RUN_CNT_W-1:0]   run_cnt_q, run_cnt_d;
   runmon_err_t            fault_code;
   logic                   fault_any;

   wasm_fault_encoder u_fault_enc (
      .i_instr_error     (i_instr_error),
      .i_stack_exceed    (i_stack_exceed),
      .i_stack_empty_pop (i_stack_empty_pop),
      .o_code            (fault_code),
      .o_any             (fault_any)
   );

   // Next-state logic: launch, reset hold, run termination priority and re-arm/clear.
   always_comb begin
      state_d      = state_q;
      hold_d       = hold_q;
      core_rst_n_d = core_rst_n_q;
      pass_d       = pass_q;
      err_d        = err_q;
      cnt_d        = cnt_q;
      err_cycle_d  = err_cycle_q;
      run_cnt_d    = run_cnt_q;
      case (state_q)
         RUNMON_IDLE: begin
            core_rst_n_d = 1'b0;
            if (i_start) begin
               state_d = RUNMON_HOLD;
               hold_d  = HOLD_INIT;
               cnt_d   = '0;
               err_d   = RUNMON_ERR_NONE;
            end
         end
         RUNMON_HOLD: begin
            if (hold_q == '0) begin
               state_d      = RUNMON_RUN;
               core_rst_n_d = 1'b1;
            end else begin
               hold_d = hold_q - HOLD_W'(1);
            end
         end
         RUNMON_RUN: begin
            if (fault_any || i_instr_finish || cnt_q == CNT_LAST) begin
               state_d     = RUNMON_DONE;
               err_cycle_d = cnt_q;
               run_cnt_d   = run_cnt_q + RUN_CNT_W'(1);
               pass_d      = !fault_any && i_instr_finish;
               err_d       = fault_any ? fault_code : i_instr_finish ? RUNMON_ERR_NONE : RUNMON_ERR_TIMEOUT;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         default: begin
            if (i_start) begin
               state_d      = RUNMON_HOLD;
               hold_d       = HOLD_INIT;
               core_rst_n_d = 1'b0;
               cnt_d        = '0;
               pass_d       = 1'b0;
               err_d        = RUNMON_ERR_NONE;
            end else if (i_clear) begin
               state_d      = RUNMON_IDLE;
               core_rst_n_d = 1'b0;
               pass_d       = 1'b0;
               err_d        = RUNMON_ERR_NONE;
            end
         end
      endcase
   end

   // State and counter registers with synchronous active-low reset.
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         state_q      <= RUNMON_IDLE;
         hold_q       <= '0;
         core_rst_n_q <= 1'b0;
         pass_q       <= 1'b0;
         err_q        <= RUNMON_ERR_NONE;
         cnt_q        <= '0;
         err_cycle_q  <= '0;
         run_cnt_q    <= '0;
      end else begin
         state_q      <= state_d;
         hold_q       <= hold_d;
         core_rst_n_q <= core_rst_n_d;
         pass_q       <= pass_d;
         err_q        <= err_d;
         cnt_q        <= cnt_d;
         err_cycle_q  <= err_cycle_d;
         run_cnt_q    <= run_cnt_d;
      end
   end

   assign o_core_rst_n = core_rst_n_q;
   assign o_busy       = (state_q == RUNMON_HOLD) || (state_q == RUNMON_RUN);
   assign o_done       = (state_q == RUNMON_DONE);
   assign o_pass       = pass_q;
   assign o_err_code   = err_q;
   assign o_cycle_cnt  = cnt_q;
   assign o_err_cycle  = err_cycle_q;
   assign o_run_cnt    = run_cnt_q;

`ifdef WASM_RUN_STATS_EN
   logic [CNT_W-1:0] min_q, min_d, max_q, max_d;
   logic             pass_entry;

   assign pass_entry = (state_q == RUNMON_RUN) && (state_d == RUNMON_DONE) && pass_d;

   // Fastest and slowest passing run, sampled on the edge that enters DONE.
   always_comb begin
      min_d = (pass_entry && cnt_q < min_q) ? cnt_q : min_q;
      max_d = (pass_entry && cnt_q > max_q) ? cnt_q : max_q;
   end

   // Statistics registers; min starts saturated so the first pass always lands.
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         min_q <= '1;
         max_q <= '0;
      end else begin
         min_q <= min_d;
         max_q <= max_d;
      end
   end

   assign o_min_cycles = min_q;
   assign o_max_cycles = max_q;
`endif
endmodule
